// File: rtl/pool_pkg.sv
// Shared types and sizes for the row pooling block.
// Holds the window/mode/state encodings used by pool and pool_lane.
package pool_pkg;

    localparam int DWIDTH      = 16;
    localparam int DESIGN_SIZE = 16;
    localparam int MASK_WIDTH  = 16;
    localparam int AWIDTH      = DWIDTH + 2;
    localparam int ROW_WIDTH   = DESIGN_SIZE * DWIDTH;

    typedef enum logic [1:0] {
        WIN_1   = 2'b00,
        WIN_2   = 2'b01,
        WIN_4   = 2'b10,
        WIN_RSV = 2'b11
    } pool_window_e;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // log2 of the window row count; the reserved code behaves as 1 row
    function automatic logic [1:0] win_shift(input logic [1:0] w);
        logic [1:0] s;
        case (w)
            WIN_2:   s = 2'd1;
            WIN_4:   s = 2'd2;
            default: s = 2'd0;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] win_last_idx(input logic [1:0] sh);
        logic [1:0] idx;
        case (sh)
            2'd1:    idx = 2'd1;
            2'd2:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/pool_if.sv
// Row stream bundle between the upstream norm stage and pool.
// master drives rows and configuration, slave returns pooled rows.
interface pool_if;
    import pool_pkg::*;

    logic                  enable_pool;
    logic [1:0]            pool_window;
    logic                  pool_mode;
    logic                  in_data_available;
    logic [ROW_WIDTH-1:0]  inp_data;
    logic [MASK_WIDTH-1:0] validity_mask;
    logic                  inp_last;
    logic [ROW_WIDTH-1:0]  out_data;
    logic                  out_data_available;
    logic                  done_pool;

    modport master (
        output enable_pool,
        output pool_window,
        output pool_mode,
        output in_data_available,
        output inp_data,
        output validity_mask,
        output inp_last,
        input  out_data,
        input  out_data_available,
        input  done_pool
    );

    modport slave (
        input  enable_pool,
        input  pool_window,
        input  pool_mode,
        input  in_data_available,
        input  inp_data,
        input  validity_mask,
        input  inp_last,
        output out_data,
        output out_data_available,
        output done_pool
    );

endinterface

// File: rtl/pool_lane.sv
// One lane of the pooler: max/sum accumulator plus registered output select.
// The first row of a window overwrites the accumulator instead of merging.
module pool_lane
    import pool_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              accept_i,
    input  logic              first_i,
    input  logic              flush_i,
    input  logic              bypass_i,
    input  logic              mode_i,
    input  logic              valid_i,
    input  logic [1:0]        shift_i,
    input  logic [DWIDTH-1:0] row_i,
    output logic [DWIDTH-1:0] out_o
);

    logic signed [AWIDTH-1:0] acc_q, acc_d;
    logic signed [AWIDTH-1:0] row_x;
    logic signed [AWIDTH-1:0] sum;
    logic signed [AWIDTH-1:0] avg;
    logic signed [DWIDTH-1:0] acc_lo;
    logic signed [DWIDTH-1:0] mx;
    logic [DWIDTH-1:0]        pooled;
    logic [DWIDTH-1:0]        out_q, out_d;

    always_comb begin
        row_x  = {{2{row_i[DWIDTH-1]}}, row_i};
        acc_lo = acc_q[DWIDTH-1:0];
        sum    = first_i ? row_x : acc_q + row_x;
        avg    = sum >>> shift_i;
        mx     = (first_i || ($signed(row_i) > acc_lo)) ? row_i : acc_lo;
        pooled = mode_i ? DWIDTH'(avg) : mx;
        acc_d  = acc_q;
        out_d  = out_q;
        if (accept_i) begin
            if (flush_i) begin
                acc_d = '0;
                out_d = (bypass_i || !valid_i) ? row_i : pooled;
            end else begin
                acc_d = mode_i ? sum : {{2{mx[DWIDTH-1]}}, mx};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/pool.sv
// Row pooling stage: groups 1/2/4 rows per window and emits max or average.
// Holds the stream FSM, window row counter and per-stream configuration.
module pool
    import pool_pkg::*;
(
    input  logic clk,
    input  logic reset,
    pool_if.slave bus
);

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [MASK_WIDTH-1:0] mask_q, mask_d;
    logic                  en_q, en_d;
    logic [1:0]            win_q, win_d;
    logic                  mode_q, mode_d;
    logic                  avail_q, avail_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  first_row;
    logic                  win_first;
    logic                  win_done;
    logic                  en_eff;
    logic [1:0]            win_eff;
    logic                  mode_eff;
    logic [1:0]            shift_eff;
    logic [1:0]            last_idx;
    logic [MASK_WIDTH-1:0] mask_eff;
    logic [ROW_WIDTH-1:0]  out_w;

    // Configuration is live on the stream's first row, held afterwards
    always_comb begin
        accept    = bus.in_data_available && (state_q != ST_DONE);
        first_row = (state_q == ST_IDLE);
        en_eff    = first_row ? bus.enable_pool : en_q;
        win_eff   = first_row ? bus.pool_window : win_q;
        mode_eff  = first_row ? bus.pool_mode : mode_q;
        shift_eff = en_eff ? win_shift(win_eff) : 2'd0;
        last_idx  = win_last_idx(shift_eff);
        win_first = (cnt_q == 2'd0);
        mask_eff  = win_first ? bus.validity_mask : mask_q;
        win_done  = accept && ((cnt_q == last_idx) || bus.inp_last);
        avail_d   = win_done;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        en_d    = en_q;
        win_d   = win_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    en_d    = bus.enable_pool;
                    win_d   = bus.pool_window;
                    mode_d  = bus.pool_mode;
                    state_d = bus.inp_last ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept && bus.inp_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            cnt_d = win_done ? 2'd0 : cnt_q + 2'd1;
            if (win_first) begin
                mask_d = bus.validity_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            en_q    <= 1'b0;
            win_q   <= '0;
            mode_q  <= 1'b0;
            avail_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            en_q    <= en_d;
            win_q   <= win_d;
            mode_q  <= mode_d;
            avail_q <= avail_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < DESIGN_SIZE; i++) begin : g_lane
        pool_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .accept_i (accept),
            .first_i  (win_first),
            .flush_i  (win_done),
            .bypass_i (!en_eff),
            .mode_i   (mode_eff == MODE_AVG),
            .valid_i  (mask_eff[i]),
            .shift_i  (shift_eff),
            .row_i    (bus.inp_data[i*DWIDTH +: DWIDTH]),
            .out_o    (out_w[i*DWIDTH +: DWIDTH])
        );
    end

    assign bus.out_data           = out_w;
    assign bus.out_data_available = avail_q;
    assign bus.done_pool          = done_q;

endmodule
